// File: rtl/ifetch_stage.sv
// rtl/ifetch_stage.sv - instruction fetch stage: PC register, imem req/ack FSM, next-PC resolution
module ifetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          IMEM_AW  = 14
) (
   input  logic               clock,
   input  logic               reset,
   output logic               imem_req,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic               imem_ack,
   input  logic [31:0]        imem_rdata,
   output logic [31:0]        Instruction,
   output logic               inst_valid,
   output logic [31:0]        opcplus4,
   output logic [31:0]        pc,
   input  logic               stall,
   input  logic               Branch,
   input  logic               nBranch,
   input  logic               Jmp,
   input  logic               Jal,
   input  logic               Jr,
   input  logic               Zero,
   input  logic [31:0]        Addr_result,
   input  logic [31:0]        Read_data_1,
   output logic               pc_misalign
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        inst_valid_q, inst_valid_d;
   logic        imem_req_q, imem_req_d;
   logic        pc_misalign_q, pc_misalign_d;

   logic [31:0] seq_pc;
   logic [31:0] next_pc;
   logic        take_branch;

   assign seq_pc      = pc_q + 32'd4;
   assign take_branch = (Branch & Zero) | (nBranch & ~Zero);

   // Jr outranks jumps, which outrank conditional branches; targets are forced word aligned.
   always_comb begin
      next_pc = seq_pc;
      if (Jr) begin
         next_pc = Read_data_1 & ~32'h3;
      end else if (Jmp || Jal) begin
         next_pc = {seq_pc[31:28], instr_q[25:0], 2'b00};
      end else if (take_branch) begin
         next_pc = Addr_result & ~32'h3;
      end
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      inst_valid_d  = inst_valid_q;
      imem_req_d    = imem_req_q;
      pc_misalign_d = pc_misalign_q;
      case (state_q)
         IDLE: begin
            state_d    = FETCH;
            imem_req_d = 1'b1;
         end
         FETCH: begin
            if (imem_ack) begin
               instr_d      = imem_rdata;
               inst_valid_d = 1'b1;
               imem_req_d   = 1'b0;
               state_d      = EXEC;
            end
         end
         EXEC: begin
            if (!stall) begin
               pc_d         = next_pc;
               inst_valid_d = 1'b0;
               imem_req_d   = 1'b1;
               state_d      = FETCH;
               if (Jr && (Read_data_1[1:0] != 2'b00)) begin
                  pc_misalign_d = 1'b1;
               end
            end
         end
         default: begin
            state_d    = IDLE;
            imem_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         pc_q          <= RESET_PC;
         instr_q       <= 32'h0;
         inst_valid_q  <= 1'b0;
         imem_req_q    <= 1'b0;
         pc_misalign_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         inst_valid_q  <= inst_valid_d;
         imem_req_q    <= imem_req_d;
         pc_misalign_q <= pc_misalign_d;
      end
   end

   assign imem_req    = imem_req_q;
   assign imem_addr   = pc_q[IMEM_AW+1:2];
   assign Instruction = instr_q;
   assign inst_valid  = inst_valid_q;
   assign pc          = pc_q;
   assign opcplus4    = seq_pc;
   assign pc_misalign = pc_misalign_q;

endmodule

// File: tb/tb_ifetch_stage.sv
// tb/tb_ifetch_stage.sv - directed self-checking bench for ifetch_stage
module tb_ifetch_stage;

   logic        clock = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [13:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] Instruction;
   logic        inst_valid;
   logic [31:0] opcplus4;
   logic [31:0] pc;
   logic        stall;
   logic        Branch, nBranch, Jmp, Jal, Jr, Zero;
   logic [31:0] Addr_result;
   logic [31:0] Read_data_1;
   logic        pc_misalign;

   int tests_run = 0;
   int tests_failed = 0;

   ifetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_AW(14)) dut (
      .clock       (clock),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .Instruction (Instruction),
      .inst_valid  (inst_valid),
      .opcplus4    (opcplus4),
      .pc          (pc),
      .stall       (stall),
      .Branch      (Branch),
      .nBranch     (nBranch),
      .Jmp         (Jmp),
      .Jal         (Jal),
      .Jr          (Jr),
      .Zero        (Zero),
      .Addr_result (Addr_result),
      .Read_data_1 (Read_data_1),
      .pc_misalign (pc_misalign)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic clear_ctrl;
      Branch = 0; nBranch = 0; Jmp = 0; Jal = 0; Jr = 0; Zero = 0;
      Addr_result = 32'hDEAD_BEE3; Read_data_1 = 32'hCAFE_F00D;
   endtask

   // Wait 'waits' cycles with ack low, then ack 'word'; ends in EXEC.
   task automatic do_fetch(input logic [31:0] word, input int waits, input logic [31:0] exp_pc);
      logic [31:0] prev_instr;
      prev_instr = Instruction;
      for (int w = 0; w < waits; w++) begin
         check("wait_req", 32'(imem_req), 32'd1);
         check("wait_addr", 32'(imem_addr), 32'(exp_pc[15:2]));
         tick();
         check("wait_instr_hold", Instruction, prev_instr);
      end
      check("fetch_req", 32'(imem_req), 32'd1);
      check("fetch_addr", 32'(imem_addr), 32'(exp_pc[15:2]));
      check("fetch_valid_lo", 32'(inst_valid), 32'd0);
      imem_rdata = word;
      imem_ack   = 1'b1;
      tick();
      imem_ack   = 1'b0;
      imem_rdata = 32'h5A5A_5A5A;
      check("exec_instr", Instruction, word);
      check("exec_valid", 32'(inst_valid), 32'd1);
      check("exec_req", 32'(imem_req), 32'd0);
      check("exec_pc", pc, exp_pc);
      check("exec_opcplus4", opcplus4, exp_pc + 32'd4);
   endtask

   task automatic retire(input logic [31:0] exp_next);
      stall = 1'b0;
      tick();
      clear_ctrl();
      check("retire_valid", 32'(inst_valid), 32'd0);
      check("retire_req", 32'(imem_req), 32'd1);
      check("retire_pc", pc, exp_next);
   endtask

   initial begin
      reset = 1'b0;
      imem_ack = 1'b0;
      imem_rdata = 32'h0;
      stall = 1'b0;
      clear_ctrl();
      tick();
      tick();
      check("rst_pc", pc, 32'h0);
      check("rst_instr", Instruction, 32'h0);
      check("rst_valid", 32'(inst_valid), 32'd0);
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_misalign", 32'(pc_misalign), 32'd0);
      check("rst_opcplus4", opcplus4, 32'h4);

      reset = 1'b1;
      check("idle_req", 32'(imem_req), 32'd0);
      tick();
      check("first_fetch_req", 32'(imem_req), 32'd1);

      // Sequential fetches, one instruction every two cycles
      for (int i = 0; i < 4; i++) begin
         check("seq_addr", 32'(imem_addr), i);
         do_fetch(32'h1000_0000 + i, 0, 32'(4 * i));
         retire(32'(4 * (i + 1)));
      end

      // Three ack-wait cycles, plus an ack during a stalled EXEC that must be ignored
      do_fetch(32'hAAAA_0001, 3, 32'h10);
      stall = 1'b1;
      imem_ack = 1'b1;
      imem_rdata = 32'hBAD0_BAD0;
      tick();
      imem_ack = 1'b0;
      check("ack_in_exec_ignored", Instruction, 32'hAAAA_0001);
      Branch = 1; Zero = 1; Addr_result = 32'h40;
      retire(32'h40);

      do_fetch(32'h1000_0005, 0, 32'h40);
      Branch = 1; Zero = 0; Addr_result = 32'h400;
      retire(32'h44);

      do_fetch(32'h1400_0005, 0, 32'h44);
      nBranch = 1; Zero = 0; Addr_result = 32'h83;
      retire(32'h80);

      do_fetch(32'h0000_0008, 0, 32'h80);
      Jr = 1; Read_data_1 = 32'h1000_0008;
      retire(32'h1000_0008);
      check("aligned_jr_no_misalign", 32'(pc_misalign), 32'd0);

      // jal: link address visible during EXEC, target keeps pc+4 top nibble
      do_fetch(32'h0C00_0010, 0, 32'h1000_0008);
      Jal = 1;
      retire(32'h1000_0040);

      // PC and word address wrap
      do_fetch(32'h0000_0008, 0, 32'h1000_0040);
      Jr = 1; Read_data_1 = 32'hFFFF_FFFC;
      retire(32'hFFFF_FFFC);
      check("wrap_addr_top", 32'(imem_addr), 32'h3FFF);
      do_fetch(32'h0000_0000, 0, 32'hFFFF_FFFC);
      check("wrap_opcplus4", opcplus4, 32'h0);
      retire(32'h0);
      check("wrap_addr_zero", 32'(imem_addr), 32'h0);

      // Jr beats Jmp; misaligned target sets sticky flag
      do_fetch(32'h0800_0005, 0, 32'h0);
      Jr = 1; Jmp = 1; Read_data_1 = 32'h0000_0123;
      retire(32'h120);
      check("misalign_set", 32'(pc_misalign), 32'd1);
      stall = 1'b1;
      do_fetch(32'h1234_5678, 1, 32'h120);
      for (int s = 0; s < 5; s++) begin
         Jr = 1; Read_data_1 = 32'h0000_0800; Branch = 1; Zero = 1;
         tick();
         check("stall_pc", pc, 32'h120);
         check("stall_instr", Instruction, 32'h1234_5678);
         check("stall_valid", 32'(inst_valid), 32'd1);
         check("stall_req", 32'(imem_req), 32'd0);
      end
      clear_ctrl();
      retire(32'h124);
      check("misalign_sticky", 32'(pc_misalign), 32'd1);

      // Reset mid-fetch takes effect without a clock edge
      tick();
      check("pre_reset_req", 32'(imem_req), 32'd1);
      reset = 1'b0;
      #1;
      check("async_rst_req", 32'(imem_req), 32'd0);
      check("async_rst_pc", pc, 32'h0);
      check("async_rst_misalign", 32'(pc_misalign), 32'd0);
      imem_ack = 1'b1;
      imem_rdata = 32'hFEED_FACE;
      tick();
      tick();
      check("rst_ack_ignored_valid", 32'(inst_valid), 32'd0);
      check("rst_ack_ignored_instr", Instruction, 32'h0);
      imem_ack = 1'b0;
      reset = 1'b1;
      tick();
      check("rerun_req", 32'(imem_req), 32'd1);
      check("rerun_addr", 32'(imem_addr), 32'h0);
      check("rerun_valid", 32'(inst_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/ifetch_stage.md
# ifetch_stage

Instruction-fetch stage of the CPU: holds the program counter, fetches one 32-bit instruction per step from instruction memory over a req/ack handshake, and presents it with its link address to the register-file/decode stage. It resolves the next PC from controller and ALU results (sequential, branch, jump, jal, jr) and can be stalled by downstream logic. It replaces a bare PC register with a small FSM so instruction memory may take a variable number of cycles.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- IMEM_AW, 14, instruction-memory word-address width
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request, held until imem_ack
- imem_addr  out  IMEM_AW  word address = pc[IMEM_AW+1:2]
- imem_ack  in  1  instruction memory has imem_rdata valid this cycle
- imem_rdata  in  32  instruction word
- Instruction  out  32  registered instruction currently being executed
- inst_valid  out  1  Instruction is valid and not yet retired
- opcplus4  out  32  pc + 4 (link address for jal)
- pc  out  32  address of Instruction
- stall  in  1  downstream not ready; hold current instruction
- Branch, nBranch, Jmp, Jal, Jr  in  1 each  controller decodes of Instruction
- Zero  in  1  ALU zero flag
- Addr_result  in  32  branch target from ALU
- Read_data_1  in  32  rs value (jr target)
- pc_misalign  out  1  sticky: a jr target had nonzero bits [1:0]

## Operation
- States: IDLE, FETCH, EXEC.
- IDLE: entered on reset; one cycle after reset release -> FETCH.
- FETCH: imem_req=1, imem_addr from pc, both stable until ack. On edge with imem_ack=1: Instruction <= imem_rdata, inst_valid <= 1, -> EXEC.
- EXEC: imem_req=0. If stall=1, hold all state. If stall=0 on an edge: pc <= next_pc, inst_valid <= 0, -> FETCH.
- next_pc priority (first match): Jr -> {Read_data_1[31:2],2'b00}; Jmp or Jal -> {seq[31:28], Instruction[25:0], 2'b00}; (Branch & Zero) or (nBranch & ~Zero) -> {Addr_result[31:2],2'b00}; else seq = pc + 4.
- Jr with Read_data_1[1:0] != 0 sets pc_misalign (sticky until reset); target still taken with low bits cleared.
- All PC arithmetic modulo 2^32; pc 32'hFFFF_FFFC + 4 -> 0. imem_addr truncates pc, so fetch wraps within memory.
- imem_ack outside FETCH is ignored; imem_rdata is sampled only on the ack edge.
- opcplus4 is combinational pc + 4, always consistent with Instruction.

## Timing
- Reset values: pc=RESET_PC, Instruction=32'h0 (nop), inst_valid=0, imem_req=0, pc_misalign=0, state=IDLE; opcplus4=RESET_PC+4.
- Reset assertion mid-fetch drops imem_req immediately (asynchronous); a later ack is ignored.
- Minimum 2 cycles per instruction (ack in the first FETCH cycle, no stall); each extra ack wait or stall cycle adds one.
- Control/Zero/Addr_result/Read_data_1 are sampled only on the retiring edge (EXEC, stall=0).
- stall in FETCH has no effect; it is applied on entry to EXEC.

## Test plan
- Reset with RESET_PC=0, release, ack immediately each fetch, no control -> imem_addr 0,1,2,3 on successive FETCH cycles; pc 0,4,8,12; one instruction every 2 cycles.
- Hold imem_ack low 3 cycles in FETCH -> imem_req high and imem_addr stable for 4 cycles; Instruction updates only on the ack edge.
- In EXEC set Branch=1, Zero=1, Addr_result=0x40; repeat with Zero=0 -> next pc 0x40, then pc+4.
- Instruction=0x0C00_0010 (jal) at pc=0x1000_0008 with Jal=1 -> opcplus4=0x1000_000C during EXEC; next pc=0x1000_0040.
- Jr=1 with Read_data_1=0x0000_0123 and Jmp=1 simultaneously -> next pc 0x120, pc_misalign=1 and stays 1 until reset.
- stall=1 for 5 EXEC cycles, then assert reset mid-FETCH -> Instruction/pc hold during stall; on reset imem_req=0 and pc=RESET_PC at once.
